// File: rtl/light_seq_pkg.sv
// Shared FSM encoding for the light sequencer.
package light_seq_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] MANUAL = 2'd0;
  localparam logic [STATE_W-1:0] WHITE  = 2'd1;
  localparam logic [STATE_W-1:0] COLOUR = 2'd2;
  localparam logic [STATE_W-1:0] STEP   = 2'd3;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the input and flags a 0->1 transition.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/light_sequencer.sv
// Drives the RGB/white selector's sel/button from either manual requests or a
// timed auto show: a white dwell followed by a round of STEPS colour steps.
module light_sequencer
  import light_seq_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter int STEPS   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               auto_en,
  input  logic               man_sel,
  input  logic               man_button,
  input  logic [DWELL_W-1:0] dwell,
  output logic               sel,
  output logic               button,
  output logic [1:0]         state,
  output logic [2:0]         step_cnt
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DWELL_W-1:0] timer_q, timer_d;
  logic [2:0]         step_q, step_d;
  logic               sel_q, sel_d;
  logic               btn_q, btn_d;
  logic               man_rise;
  logic [DWELL_W-1:0] reload;
  logic [3:0]         step_inc;

  rise_detect u_rise (
    .clk   (clk),
    .rst   (rst),
    .d     (man_button),
    .pulse (man_rise)
  );

  // A zero dwell behaves as a one-cycle period.
  assign reload   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign step_inc = {1'b0, step_q} + 4'd1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step_d  = step_q;
    sel_d   = sel_q;
    btn_d   = 1'b0;
    if (state_q != MANUAL && !auto_en) begin
      state_d = MANUAL;
      timer_d = '0;
      step_d  = '0;
      sel_d   = man_sel;
    end else begin
      case (state_q)
        MANUAL: begin
          sel_d = man_sel;
          btn_d = man_rise;
          if (auto_en) begin
            state_d = WHITE;
            timer_d = reload;
            step_d  = '0;
            sel_d   = 1'b0;
            btn_d   = 1'b0;
          end
        end
        WHITE: begin
          sel_d = 1'b0;
          if (timer_q == '0) begin
            state_d = COLOUR;
            timer_d = reload;
            sel_d   = 1'b1;
          end else begin
            timer_d = timer_q - DWELL_W'(1);
          end
        end
        COLOUR: begin
          sel_d = 1'b1;
          // Expiry and a manual request in the same cycle collapse into one step.
          if (timer_q == '0 || man_rise) begin
            state_d = STEP;
            btn_d   = 1'b1;
          end else begin
            timer_d = timer_q - DWELL_W'(1);
          end
        end
        default: begin
          timer_d = reload;
          if (step_inc == 4'(STEPS)) begin
            state_d = WHITE;
            step_d  = '0;
            sel_d   = 1'b0;
          end else begin
            state_d = COLOUR;
            step_d  = step_inc[2:0];
            sel_d   = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MANUAL;
      timer_q <= '0;
      step_q  <= '0;
      sel_q   <= 1'b0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      step_q  <= step_d;
      sel_q   <= sel_d;
      btn_q   <= btn_d;
    end
  end

  assign sel      = sel_q;
  assign button   = btn_q;
  assign state    = state_q;
  assign step_cnt = step_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer: vector table plus multi-cycle sequences.
module tb_light_sequencer;

  localparam int DW = 16;

  typedef struct {
    logic          ae;
    logic          ms;
    logic          mb;
    logic [DW-1:0] dw;
    logic [6:0]    exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          auto_en = 1'b0;
  logic          man_sel = 1'b0;
  logic          man_button = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic          sel, button;
  logic [1:0]    state;
  logic [2:0]    step_cnt;
  int            n_chk = 0;
  int            n_fail = 0;
  vec_t          vec [15];

  always #5 clk = ~clk;

  light_sequencer #(.DWELL_W(DW), .STEPS(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .auto_en    (auto_en),
    .man_sel    (man_sel),
    .man_button (man_button),
    .dwell      (dwell),
    .sel        (sel),
    .button     (button),
    .state      (state),
    .step_cnt   (step_cnt)
  );

  wire [6:0] obs = {state, step_cnt, sel, button};

  function automatic logic [6:0] pk(input logic [1:0] st, input int sc, input logic s, input logic b);
    return {st, 3'(sc), s, b};
  endfunction

  // Expected outputs k cycles into an auto round with effective dwell d.
  function automatic logic [6:0] round_exp(input int k, input int d);
    int m, c, j;
    if (k < d) return pk(2'd1, 0, 1'b0, 1'b0);
    m = k - d;
    c = m / (d + 1);
    j = m % (d + 1);
    if (c >= 6) return pk(2'd1, 0, 1'b0, 1'b0);
    if (j < d)  return pk(2'd2, c, 1'b1, 1'b0);
    return pk(2'd3, c, 1'b1, 1'b1);
  endfunction

  task automatic chk(input string nm, input logic [6:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%0d sc=%0d sel=%0b btn=%0b, want st=%0d sc=%0d sel=%0b btn=%0b",
               nm, obs[6:5], obs[4:2], obs[1], obs[0], exp[6:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go_auto(input int d);
    auto_en = 1'b0;
    man_button = 1'b0;
    tick();
    dwell = DW'(d);
    auto_en = 1'b1;
    tick();
  endtask

  initial begin
    int pulses;
    //            ae    ms    mb    dw     st   sc sel   btn
    vec[0]  = '{1'b0, 1'b0, 1'b0, 16'd4, pk(2'd0, 0, 1'b0, 1'b0)};
    vec[1]  = '{1'b0, 1'b1, 1'b0, 16'd4, pk(2'd0, 0, 1'b1, 1'b0)};
    vec[2]  = '{1'b0, 1'b1, 1'b1, 16'd4, pk(2'd0, 0, 1'b1, 1'b1)};
    vec[3]  = '{1'b0, 1'b1, 1'b1, 16'd4, pk(2'd0, 0, 1'b1, 1'b0)};
    vec[4]  = '{1'b0, 1'b1, 1'b1, 16'd4, pk(2'd0, 0, 1'b1, 1'b0)};
    vec[5]  = '{1'b0, 1'b1, 1'b1, 16'd4, pk(2'd0, 0, 1'b1, 1'b0)};
    vec[6]  = '{1'b0, 1'b1, 1'b1, 16'd4, pk(2'd0, 0, 1'b1, 1'b0)};
    vec[7]  = '{1'b0, 1'b0, 1'b0, 16'd4, pk(2'd0, 0, 1'b0, 1'b0)};
    vec[8]  = '{1'b0, 1'b0, 1'b1, 16'd4, pk(2'd0, 0, 1'b0, 1'b1)};
    vec[9]  = '{1'b0, 1'b0, 1'b0, 16'd4, pk(2'd0, 0, 1'b0, 1'b0)};
    vec[10] = '{1'b1, 1'b1, 1'b0, 16'd4, pk(2'd1, 0, 1'b0, 1'b0)};
    vec[11] = '{1'b1, 1'b1, 1'b0, 16'd4, pk(2'd1, 0, 1'b0, 1'b0)};
    vec[12] = '{1'b1, 1'b1, 1'b1, 16'd4, pk(2'd1, 0, 1'b0, 1'b0)};
    vec[13] = '{1'b1, 1'b1, 1'b0, 16'd4, pk(2'd1, 0, 1'b0, 1'b0)};
    vec[14] = '{1'b1, 1'b1, 1'b0, 16'd4, pk(2'd2, 0, 1'b1, 1'b0)};

    #3 chk("reset_state", pk(2'd0, 0, 1'b0, 1'b0));
    #9 rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      auto_en    = vec[i].ae;
      man_sel    = vec[i].ms;
      man_button = vec[i].mb;
      dwell      = vec[i].dw;
      tick();
      chk($sformatf("vec%0d", i), vec[i].exp);
    end

    // Full round, dwell 4.
    man_sel = 1'b0;
    go_auto(4);
    pulses = 0;
    for (int k = 0; k <= 37; k++) begin
      chk($sformatf("round_d4_k%0d", k), round_exp(k, 4));
      pulses += int'(button);
      if (k != 37) tick();
    end
    n_chk++;
    if (pulses != 6) begin
      n_fail++;
      $display("FAIL round_pulses: got %0d, want 6", pulses);
    end

    // Manual override inside COLOUR, then coincident with expiry.
    go_auto(4);
    repeat (5) tick();
    chk("ovr_colour_t2", pk(2'd2, 0, 1'b1, 1'b0));
    man_button = 1'b1;
    tick(); chk("ovr_pulse", pk(2'd3, 0, 1'b1, 1'b1));
    man_button = 1'b0;
    tick(); chk("ovr_after", pk(2'd2, 1, 1'b1, 1'b0));
    repeat (3) tick();
    chk("ovr_t0", pk(2'd2, 1, 1'b1, 1'b0));
    man_button = 1'b1;
    tick(); chk("coinc_pulse", pk(2'd3, 1, 1'b1, 1'b1));
    man_button = 1'b0;
    tick(); chk("coinc_after", pk(2'd2, 2, 1'b1, 1'b0));
    tick(); chk("coinc_nopulse1", pk(2'd2, 2, 1'b1, 1'b0));
    tick(); chk("coinc_nopulse2", pk(2'd2, 2, 1'b1, 1'b0));

    // Zero dwell acts as one.
    go_auto(0);
    for (int k = 0; k <= 13; k++) begin
      chk($sformatf("round_d0_k%0d", k), round_exp(k, 1));
      if (k != 13) tick();
    end

    // Dropping auto_en in STEP and in COLOUR.
    go_auto(4);
    repeat (8) tick();
    chk("drop_in_step_pre", pk(2'd3, 0, 1'b1, 1'b1));
    auto_en = 1'b0;
    man_sel = 1'b1;
    tick(); chk("drop_step", pk(2'd0, 0, 1'b1, 1'b0));
    man_sel = 1'b0;
    tick(); chk("drop_follow", pk(2'd0, 0, 1'b0, 1'b0));
    auto_en = 1'b1;
    tick(); chk("reenable_white", pk(2'd1, 0, 1'b0, 1'b0));
    repeat (9) tick();
    chk("drop_in_colour_pre", pk(2'd2, 1, 1'b1, 1'b0));
    auto_en = 1'b0;
    man_sel = 1'b1;
    tick(); chk("drop_colour", pk(2'd0, 0, 1'b1, 1'b0));

    // Asynchronous reset mid-pulse.
    man_sel = 1'b0;
    go_auto(4);
    repeat (8) tick();
    chk("rst_pre_step", pk(2'd3, 0, 1'b1, 1'b1));
    #2 rst = 1'b0;
    #1 chk("rst_async", pk(2'd0, 0, 1'b0, 1'b0));
    tick(); chk("rst_held", pk(2'd0, 0, 1'b0, 1'b0));
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
